// File: rtl/ata_pio_pkg.sv
// ata_pio_pkg: shared constants for the ATA PIO host engine.
//   - bus-cycle state encoding
//   - DATA_W legality check
//   - default timing-configuration values for integrators
package ata_pio_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_SETUP   = 3'd1;
    localparam state_t ST_ACTIVE  = 3'd2;
    localparam state_t ST_WAIT    = 3'd3;
    localparam state_t ST_RECOVER = 3'd4;

    localparam int unsigned CFG_SETUP_DEF   = 1;
    localparam int unsigned CFG_ACTIVE_DEF  = 2;
    localparam int unsigned CFG_RECOVER_DEF = 0;

    function automatic bit data_w_legal(input int unsigned w);
        return (w == 8) || (w == 16);
    endfunction

endpackage

// File: rtl/ata_pio_engine_sync2.sv
// ata_sync2: two-flop synchroniser for an asynchronous single-bit input.
//   clk_i  : destination clock
//   rst_i  : synchronous active-high reset, loads RESET_VAL into both flops
//   d_i    : asynchronous input
//   q_o    : synchronised output, two clk_i cycles of latency
module ata_sync2
    import ata_pio_pkg::*;
#(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/ata_pio_engine.sv
// ata_pio_engine: Avalon-MM slave to ATA/CF PIO host port.
// Runs one sequenced bus cycle per Avalon request with programmable setup,
// strobe and recovery timing, IORDY stretching with timeout, and a latched
// maskable device interrupt.
//   csi_clockreset_*  : clock, synchronous active-high reset
//   avs_ata_*         : Avalon-MM slave (registered readdata, waitrequest)
//   cfg_*             : timing fields, each "cycles minus 1"
//   irq_*/err_*       : interrupt enable/clear, timeout flag clear
//   ins_intrq_irq     : latched interrupt to the CPU
//   err_timeout       : sticky IORDY-timeout flag
//   ATA_*             : connector pins (data bus, address, strobes, DIR,
//                       IORDY, INTRQ)
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | no cycle; a request is captured and moves to SETUP
// SETUP    | address (and write data) valid, strobes high, cfg_setup+1
// ACTIVE   | strobe low for cfg_active+1 cycles
// WAIT     | strobe held low until synced IORDY=1 or TIMEOUT cycles
// RECOVER  | strobe high, first cycle is the ack, cfg_recover+1 cycles
module ata_pio_engine
    import ata_pio_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 5,
    parameter int CNT_W   = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic              csi_clockreset_clk,
    input  logic              csi_clockreset_reset,
    input  logic [ADDR_W-1:0] avs_ata_address,
    input  logic              avs_ata_read,
    input  logic              avs_ata_write,
    input  logic [DATA_W-1:0] avs_ata_writedata,
    output logic [DATA_W-1:0] avs_ata_readdata,
    output logic              avs_ata_waitrequest,
    input  logic [CNT_W-1:0]  cfg_setup,
    input  logic [CNT_W-1:0]  cfg_active,
    input  logic [CNT_W-1:0]  cfg_recover,
    input  logic              irq_en,
    input  logic              irq_clear,
    input  logic              err_clear,
    output logic              ins_intrq_irq,
    output logic              err_timeout,
    inout  wire  [DATA_W-1:0] ATA_DATA,
    output logic [ADDR_W-1:0] ATA_ADDR,
    output logic              ATA_OEN,
    output logic              ATA_WEN,
    output logic              ATA_DATA_DIR,
    input  logic              ATA_WAITN,
    input  logic              ATA_INTRQ
);

    if (!data_w_legal(DATA_W)) begin : g_bad_data_w
        $error("ata_pio_engine: DATA_W must be 8 or 16");
    end

    // One down-counter serves every timed state; it must also hold TIMEOUT-1.
    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int TMR_W  = (WAIT_W > CNT_W) ? WAIT_W : CNT_W;
    localparam logic [TMR_W-1:0] WAIT_LOAD = TMR_W'(TIMEOUT - 1);

    logic              clk;
    logic              rst;
    logic              iordy_s;
    logic              intrq_s;

    state_t            state_q,  state_d;
    logic [TMR_W-1:0]  tmr_q,    tmr_d;
    logic              wr_q,     wr_d;
    logic [ADDR_W-1:0] addr_q,   addr_d;
    logic [DATA_W-1:0] wdata_q,  wdata_d;
    logic [DATA_W-1:0] rdata_q,  rdata_d;
    logic              ack_q,    ack_d;
    logic              oen_q,    oen_d;
    logic              wen_q,    wen_d;
    logic              drive_q,  drive_d;
    logic              irq_q,    irq_d;
    logic              err_q,    err_d;
    logic              intrq_prev_q;
    logic              strobe_end;
    logic              timeout_evt;
    logic              strobing_d;

    assign clk = csi_clockreset_clk;
    assign rst = csi_clockreset_reset;

    ata_sync2 #(.RESET_VAL(1'b0)) u_sync_iordy (
        .clk_i (clk),
        .rst_i (rst),
        .d_i   (ATA_WAITN),
        .q_o   (iordy_s)
    );

    ata_sync2 #(.RESET_VAL(1'b0)) u_sync_intrq (
        .clk_i (clk),
        .rst_i (rst),
        .d_i   (ATA_INTRQ),
        .q_o   (intrq_s)
    );

    always_comb begin
        state_d     = state_q;
        tmr_d       = tmr_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        ack_d       = 1'b0;
        strobe_end  = 1'b0;
        timeout_evt = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (avs_ata_read || avs_ata_write) begin
                    state_d = ST_SETUP;
                    tmr_d   = TMR_W'(cfg_setup);
                    wr_d    = avs_ata_write;   // write wins when both are set
                    addr_d  = avs_ata_address;
                    wdata_d = avs_ata_writedata;
                end
            end
            ST_SETUP: begin
                if (tmr_q == '0) begin
                    state_d = ST_ACTIVE;
                    tmr_d   = TMR_W'(cfg_active);
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            ST_ACTIVE: begin
                if (tmr_q != '0) begin
                    tmr_d = tmr_q - TMR_W'(1);
                end else if (iordy_s) begin
                    strobe_end = 1'b1;
                end else begin
                    state_d = ST_WAIT;
                    tmr_d   = WAIT_LOAD;
                end
            end
            ST_WAIT: begin
                if (iordy_s) begin
                    strobe_end = 1'b1;
                end else if (tmr_q == '0) begin
                    strobe_end  = 1'b1;
                    timeout_evt = 1'b1;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            ST_RECOVER: begin
                if (tmr_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Leaving the strobe: ack next cycle, latch the device's last bus value.
        if (strobe_end) begin
            state_d = ST_RECOVER;
            tmr_d   = TMR_W'(cfg_recover);
            ack_d   = 1'b1;
            if (!wr_q) begin
                rdata_d = timeout_evt ? '1 : ATA_DATA;
            end
        end
    end

    // Pin controls are registered from next-state so the strobes are glitch-free.
    // Write data stays on the bus through the ack cycle for device hold time.
    always_comb begin
        strobing_d = (state_d == ST_ACTIVE) || (state_d == ST_WAIT);
        oen_d      = ~(strobing_d & ~wr_d);
        wen_d      = ~(strobing_d & wr_d);
        drive_d    = wr_d & ((state_d == ST_SETUP) | strobing_d | ack_d);
        irq_d      = irq_q;
        if (intrq_s && !intrq_prev_q && irq_en) begin
            irq_d = 1'b1;
        end else if (irq_clear) begin
            irq_d = 1'b0;
        end
        err_d = err_q;
        if (timeout_evt) begin
            err_d = 1'b1;
        end else if (err_clear) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            tmr_q        <= '0;
            wr_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            ack_q        <= 1'b0;
            oen_q        <= 1'b1;
            wen_q        <= 1'b1;
            drive_q      <= 1'b0;
            irq_q        <= 1'b0;
            err_q        <= 1'b0;
            intrq_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            tmr_q        <= tmr_d;
            wr_q         <= wr_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            ack_q        <= ack_d;
            oen_q        <= oen_d;
            wen_q        <= wen_d;
            drive_q      <= drive_d;
            irq_q        <= irq_d;
            err_q        <= err_d;
            intrq_prev_q <= intrq_s;
        end
    end

    assign avs_ata_waitrequest = (avs_ata_read | avs_ata_write) & ~ack_q;
    assign avs_ata_readdata    = rdata_q;
    assign ins_intrq_irq       = irq_q;
    assign err_timeout         = err_q;
    assign ATA_ADDR            = addr_q;
    assign ATA_OEN             = oen_q;
    assign ATA_WEN             = wen_q;
    assign ATA_DATA_DIR        = ~drive_q;
    assign ATA_DATA            = drive_q ? wdata_q : {DATA_W{1'bz}};

endmodule
